// File: rtl/spram_banked_fifo.sv
// Valid/ready FIFO over two interleaved single-port RAM banks (even/odd words)
// with a 2-entry registered output buffer. Define SPRAM_FIFO_PARITY_EN for stored parity + par_err.
module spram_banked_fifo #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int ADDR_W    = $clog2(DEPTH),
  parameter int LVL_W     = $clog2(DEPTH + 3)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [LVL_W-1:0]  level,
  output logic              almost_full,
  output logic              empty
`ifdef SPRAM_FIFO_PARITY_EN
  ,
  output logic              par_err
`endif
);
`ifdef SPRAM_FIFO_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif
  localparam int ROW_W  = ADDR_W - 1;
  localparam int BANK_D = DEPTH / 2;
  localparam logic [ADDR_W:0]  FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [LVL_W-1:0] AF_LVL   = LVL_W'(AF_THRESH);

  logic [ADDR_W:0]        wp_q, rp_q, ram_cnt;
  logic                   rd_pend_q, rd_bank_q, rd_turn_q;
  logic [1:0]             buf_cnt_q, buf_cnt_d;
  logic [1:0][DATA_W-1:0] buf_q, buf_d;
  logic [LVL_W-1:0]       level_q, level_d;
  logic                   af_q, empty_q;
  logic                   pop, rd_req, wr_try, conflict, rd_go, push;
  logic [2:0]             occ;
  logic [MEM_W-1:0]       wword, cap_word;
  logic [DATA_W-1:0]      cap_data;
  logic [1:0]             bank_we, bank_re;
  logic [1:0][ROW_W-1:0]  bank_addr;
  logic [1:0][MEM_W-1:0]  bank_rdata;

  assign ram_cnt   = wp_q - rp_q;
  assign out_valid = (buf_cnt_q != 2'd0);
  assign pop       = out_valid && out_ready && !flush;
  // buffer slots already committed after this cycle's pop
  assign occ       = 3'(buf_cnt_q) + 3'(rd_pend_q) - 3'(pop);
  assign rd_req    = (ram_cnt != '0) && (occ < 3'd2) && !flush;
  assign wr_try    = in_valid && rst && !flush && (ram_cnt != FULL_CNT);
  assign conflict  = rd_req && wr_try && (wp_q[0] == rp_q[0]);
  // rd_turn_q=0 lets write win; it toggles on every conflict so the sides alternate
  assign rd_go     = rd_req && !(conflict && !rd_turn_q);
  assign in_ready  = rst && !flush && (ram_cnt != FULL_CNT) && !(conflict && rd_turn_q);
  assign push      = in_valid && in_ready;

`ifdef SPRAM_FIFO_PARITY_EN
  assign wword = {^in_data, in_data};
`else
  assign wword = in_data;
`endif
  assign cap_word = bank_rdata[rd_bank_q];
  assign cap_data = cap_word[DATA_W-1:0];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic [MEM_W-1:0] mem_q [BANK_D];
    logic [MEM_W-1:0] rdata_q;
    assign bank_we[b]    = push  && (wp_q[0] == 1'(b));
    assign bank_re[b]    = rd_go && (rp_q[0] == 1'(b));
    assign bank_addr[b]  = bank_we[b] ? wp_q[ADDR_W-1:1] : rp_q[ADDR_W-1:1];
    assign bank_rdata[b] = rdata_q;
    always_ff @(posedge clk) begin
      if (bank_we[b])      mem_q[bank_addr[b]] <= wword;
      else if (bank_re[b]) rdata_q <= mem_q[bank_addr[b]];
    end
  end

  always_comb begin
    buf_d     = buf_q;
    buf_cnt_d = buf_cnt_q;
    case ({rd_pend_q, pop})
      2'b01: begin
        buf_d[0]  = buf_q[1];
        buf_cnt_d = buf_cnt_q - 2'd1;
      end
      2'b10: begin
        if (buf_cnt_q == 2'd0) buf_d[0] = cap_data;
        else                   buf_d[1] = cap_data;
        buf_cnt_d = buf_cnt_q + 2'd1;
      end
      2'b11: begin
        if (buf_cnt_q == 2'd1) buf_d[0] = cap_data;
        else begin
          buf_d[0] = buf_q[1];
          buf_d[1] = cap_data;
        end
      end
      default: ;
    endcase
    if (flush) buf_cnt_d = 2'd0;
    level_d = flush ? '0 : level_q + LVL_W'(push) - LVL_W'(pop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp_q      <= '0;
      rp_q      <= '0;
      rd_pend_q <= 1'b0;
      rd_bank_q <= 1'b0;
      buf_cnt_q <= 2'd0;
      buf_q     <= '0;
      level_q   <= '0;
      af_q      <= 1'b0;
      empty_q   <= 1'b1;
    end else begin
      if (flush) begin
        wp_q      <= '0;
        rp_q      <= '0;
        rd_pend_q <= 1'b0;
      end else begin
        if (push)  wp_q <= wp_q + 1'b1;
        if (rd_go) begin
          rp_q      <= rp_q + 1'b1;
          rd_bank_q <= rp_q[0];
        end
        rd_pend_q <= rd_go;
      end
      buf_cnt_q <= buf_cnt_d;
      buf_q     <= buf_d;
      level_q   <= level_d;
      af_q      <= (level_d >= AF_LVL);
      empty_q   <= (level_d == '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          rd_turn_q <= 1'b0;
    else if (conflict) rd_turn_q <= ~rd_turn_q;
  end

`ifdef SPRAM_FIFO_PARITY_EN
  logic par_err_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                         par_err_q <= 1'b0;
    else if (flush)                   par_err_q <= 1'b0;
    else if (rd_pend_q && ^cap_word)  par_err_q <= 1'b1;
  end
  assign par_err = par_err_q;
`endif

  assign out_data    = buf_q[0];
  assign level       = level_q;
  assign almost_full = af_q;
  assign empty       = empty_q;
endmodule

// File: tb/tb_spram_banked_fifo.sv
// Bench for spram_banked_fifo: queue-based reference model, scenario tasks, random traffic.
module tb_spram_banked_fifo;
  localparam int DW = 32, D = 8, AF = 6, LW = $clog2(D + 3);

  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic in_ready, out_valid, almost_full, empty;
  logic [DW-1:0] out_data;
  logic [LW-1:0] level;
`ifdef SPRAM_FIFO_PARITY_EN
  logic par_err;
`endif

  int n_chk = 0, n_pass = 0;
  logic [DW-1:0] q[$];
  logic got_rdy, got_acc, got_pop;
  logic [DW-1:0] got_data, exp_data;

  always #5 clk = ~clk;

  spram_banked_fifo #(.DATA_W(DW), .DEPTH(D), .AF_THRESH(AF)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .level(level), .almost_full(almost_full), .empty(empty)
`ifdef SPRAM_FIFO_PARITY_EN
    , .par_err(par_err)
`endif
  );

  // One clock: sample handshakes mid-cycle, update model, return just after the edge.
  task automatic step();
    @(negedge clk);
    got_rdy  = in_ready;
    got_acc  = in_valid && in_ready;
    got_pop  = out_valid && out_ready && !flush;
    got_data = out_data;
    exp_data = 'x;
    if (flush) q.delete();
    else begin
      if (got_pop && q.size() > 0) exp_data = q.pop_front();
      if (got_acc) q.push_back(in_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    @(negedge clk); rst = 1'b1; q.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    in_valid = 1'b1; out_ready = 1'b1;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk); #1;
    n_chk++; if (in_ready !== 1'b0)   $display("FAIL reset_in_ready: got %b exp 0", in_ready);   else n_pass++;
    n_chk++; if (out_valid !== 1'b0)  $display("FAIL reset_out_valid: got %b exp 0", out_valid); else n_pass++;
    n_chk++; if (out_data !== '0)     $display("FAIL reset_out_data: got %h exp 0", out_data);   else n_pass++;
    n_chk++; if (level !== '0)        $display("FAIL reset_level: got %0d exp 0", level);        else n_pass++;
    n_chk++; if (empty !== 1'b1)      $display("FAIL reset_empty: got %b exp 1", empty);         else n_pass++;
    n_chk++; if (almost_full !== 1'b0) $display("FAIL reset_af: got %b exp 0", almost_full);     else n_pass++;
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk); rst = 1'b1; q.delete();
    @(posedge clk); #1;
    n_chk++; if (in_ready !== 1'b1)   $display("FAIL release_in_ready: got %b exp 1", in_ready); else n_pass++;
  endtask

  // Push one word into an empty FIFO and check the two-cycle latency.
  task automatic test_latency(input logic [DW-1:0] w, input string nm);
    in_data = w; in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    n_chk++; if (got_acc !== 1'b1)   $display("FAIL %s_accept: got %b exp 1", nm, got_acc);     else n_pass++;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL %s_c0_valid: got %b exp 0", nm, out_valid); else n_pass++;
    step();
    n_chk++; if (out_valid !== 1'b0) $display("FAIL %s_c1_valid: got %b exp 0", nm, out_valid); else n_pass++;
    step();
    n_chk++; if (out_valid !== 1'b1) $display("FAIL %s_c2_valid: got %b exp 1", nm, out_valid); else n_pass++;
    n_chk++; if (out_data !== w)     $display("FAIL %s_c2_data: got %h exp %h", nm, out_data, w); else n_pass++;
    n_chk++; if (level !== LW'(1))   $display("FAIL %s_level: got %0d exp 1", nm, level);       else n_pass++;
    n_chk++; if (empty !== 1'b0)     $display("FAIL %s_empty: got %b exp 0", nm, empty);        else n_pass++;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_chk++; if (!got_pop || got_data !== w) $display("FAIL %s_pop: got %b/%h exp 1/%h", nm, got_pop, got_data, w); else n_pass++;
    n_chk++; if (empty !== 1'b1)     $display("FAIL %s_empty_after: got %b exp 1", nm, empty);  else n_pass++;
  endtask

  task automatic test_fill();
    int acc_n, k;
    acc_n = 0; k = 0;
    out_ready = 1'b0; in_valid = 1'b1; in_data = '0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (got_acc) begin acc_n++; in_data = DW'(acc_n); end
      n_chk++; if (level !== LW'(q.size())) $display("FAIL fill_level: got %0d exp %0d", level, q.size()); else n_pass++;
      n_chk++; if (almost_full !== (q.size() >= AF)) $display("FAIL fill_af: got %b at level %0d", almost_full, q.size()); else n_pass++;
    end
    in_valid = 1'b0;
    n_chk++; if (acc_n != 10)          $display("FAIL fill_accepted: got %0d exp 10", acc_n);  else n_pass++;
    n_chk++; if (in_ready !== 1'b0)    $display("FAIL fill_in_ready: got %b exp 0", in_ready); else n_pass++;
    n_chk++; if (level !== LW'(10))    $display("FAIL fill_level_max: got %0d exp 10", level); else n_pass++;
    out_ready = 1'b1;
    for (int t = 0; t < 40 && q.size() > 0; t++) begin
      step();
      if (got_pop) begin
        n_chk++; if (got_data !== DW'(k)) $display("FAIL fill_order: got %h exp %h", got_data, DW'(k)); else n_pass++;
        k++;
      end
    end
    out_ready = 1'b0;
    n_chk++; if (k != 10) $display("FAIL fill_drain_count: got %0d exp 10", k); else n_pass++;
  endtask

  // Park two words in RAM and two in the buffer, then push+pop at once: a same-bank conflict.
  task automatic test_conflict();
    do_reset();
    for (int r = 0; r < 3; r++) begin
      int a;
      a = 0;
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hC000_0000 + DW'(r * 16);
      for (int t = 0; t < 8 && a < 4; t++) begin
        step();
        if (got_acc) begin a++; in_data = in_data + 1; end
      end
      in_valid = 1'b0;
      repeat (4) step();
      in_valid = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      n_chk++; if (got_rdy !== (r != 1)) $display("FAIL conflict_grant%0d: in_ready %b exp %b", r, got_rdy, r != 1); else n_pass++;
      for (int t = 0; t < 20 && q.size() > 0; t++) begin
        step();
        if (got_pop) begin
          n_chk++; if (got_data !== exp_data) $display("FAIL conflict_order%0d: got %h exp %h", r, got_data, exp_data); else n_pass++;
        end
      end
      out_ready = 1'b0;
      n_chk++; if (q.size() != 0 || empty !== 1'b1) $display("FAIL conflict_drain%0d: left %0d empty %b", r, q.size(), empty); else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int pops;
    pops = 0;
    in_valid = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!in_valid || got_acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = $urandom;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      step();
      if (got_pop) begin
        pops++;
        n_chk++; if (got_data !== exp_data) $display("FAIL b2b_order: got %h exp %h", got_data, exp_data); else n_pass++;
      end
      n_chk++; if (level !== LW'(q.size())) $display("FAIL b2b_level: got %0d exp %0d", level, q.size()); else n_pass++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int t = 0; t < 40 && q.size() > 0; t++) begin
      step();
      if (got_pop) begin
        pops++;
        n_chk++; if (got_data !== exp_data) $display("FAIL b2b_drain: got %h exp %h", got_data, exp_data); else n_pass++;
      end
    end
    out_ready = 1'b0;
    n_chk++; if (pops < 100 || q.size() != 0) $display("FAIL b2b_count: pops %0d left %0d", pops, q.size()); else n_pass++;
  endtask

  task automatic test_flush();
    int a;
    logic seen;
    a = 0; seen = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h100;
    for (int t = 0; t < 10 && a < 5; t++) begin
      step();
      if (got_acc) begin a++; in_data = in_data + 1; end
    end
    in_valid = 1'b0;
    repeat (3) step();
    n_chk++; if (level !== LW'(5)) $display("FAIL flush_pre_level: got %0d exp 5", level); else n_pass++;
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_data = 32'hDEAD;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    n_chk++; if (got_rdy !== 1'b0)   $display("FAIL flush_in_ready: got %b exp 0", got_rdy);   else n_pass++;
    n_chk++; if (level !== '0)       $display("FAIL flush_level: got %0d exp 0", level);       else n_pass++;
    n_chk++; if (empty !== 1'b1)     $display("FAIL flush_empty: got %b exp 1", empty);        else n_pass++;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL flush_out_valid: got %b exp 0", out_valid); else n_pass++;
    in_data = 32'hAB; in_valid = 1'b1;
    step();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int t = 0; t < 10 && !seen; t++) begin
      step();
      if (got_pop) begin
        seen = 1'b1;
        n_chk++; if (got_data !== 32'hAB) $display("FAIL flush_next: got %h exp ab", got_data); else n_pass++;
      end
    end
    out_ready = 1'b0;
    n_chk++; if (!seen) $display("FAIL flush_timeout: no output within bound"); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int a;
    a = 0;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h300;
    for (int t = 0; t < 6 && a < 3; t++) begin
      step();
      if (got_acc) begin a++; in_data = in_data + 1; end
    end
    in_valid = 1'b0;
    n_chk++; if (level !== LW'(3) || out_valid !== 1'b1) $display("FAIL rstmid_pre: level %0d valid %b exp 3/1", level, out_valid); else n_pass++;
    rst = 1'b0;
    #1;
    n_chk++; if (out_valid !== 1'b0) $display("FAIL rstmid_out_valid: got %b exp 0", out_valid); else n_pass++;
    n_chk++; if (level !== '0)       $display("FAIL rstmid_level: got %0d exp 0", level);       else n_pass++;
    n_chk++; if (empty !== 1'b1)     $display("FAIL rstmid_empty: got %b exp 1", empty);        else n_pass++;
    n_chk++; if (in_ready !== 1'b0)  $display("FAIL rstmid_in_ready: got %b exp 0", in_ready);  else n_pass++;
    @(negedge clk); rst = 1'b1; q.delete();
    @(posedge clk); #1;
    test_latency(32'h5A, "rstmid");
  endtask

`ifdef SPRAM_FIFO_PARITY_EN
  task automatic test_parity();
    int a;
    a = 0;
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h700;
    for (int t = 0; t < 20 && a < 10; t++) begin
      step();
      if (got_acc) begin a++; in_data = in_data + 1; end
    end
    in_valid = 1'b0;
    n_chk++; if (par_err !== 1'b0) $display("FAIL par_clean: got %b exp 0", par_err); else n_pass++;
    dut.g_bank[0].mem_q[1][0] = ~dut.g_bank[0].mem_q[1][0];
    out_ready = 1'b1;
    for (int t = 0; t < 30 && q.size() > 0; t++) step();
    out_ready = 1'b0;
    repeat (2) step();
    n_chk++; if (par_err !== 1'b1) $display("FAIL par_set: got %b exp 1", par_err); else n_pass++;
    flush = 1'b1; step(); flush = 1'b0;
    n_chk++; if (par_err !== 1'b0) $display("FAIL par_flush: got %b exp 0", par_err); else n_pass++;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_latency(32'h11, "single");
    test_fill();
    test_conflict();
    test_back_to_back();
    test_flush();
    test_reset_mid();
`ifdef SPRAM_FIFO_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
